fifo_sync_param: RTL and testbench
==================================

// Module: fifo_sync_param
//
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8-bit sync FIFO.
//  Generalises data width and depth, adds an occupancy count and almost-full/empty thresholds.
//  Adds sticky overflow/underflow error flags and an optional first-word-fall-through read mode.
//  Sits between sample producers (ADC/SPI capture) and consumers (UART/host readout) in the DMM FPGA.
//
// PARAMETERS
//  pDataWidth    8  data word width in bits
//  pAddrWidth    3  address bits; depth = 2**pAddrWidth words
//  pAlmostFull   6  oWrAlmostFull asserted when level >= pAlmostFull (1..depth)
//  pAlmostEmpty  1  oRdAlmostEmpty asserted when level <= pAlmostEmpty (0..depth-1)
//
// PORTS
//  iClk            in   1             single clock, rising edge
//  iRst            in   1             synchronous reset, active high
//  iWrEn           in   1             write request
//  iWrData         in   pDataWidth    write data
//  oWrFull         out  1             level == depth
//  oWrAlmostFull   out  1             level >= pAlmostFull
//  iRdEn           in   1             read request (pop/ack in FWFT mode)
//  oRdData         out  pDataWidth    read data
//  oRdValid        out  1             oRdData holds a popped/presented word
//  oRdEmpty        out  1             level == 0
//  oRdAlmostEmpty  out  1             level <= pAlmostEmpty
//  oLevel          out  pAddrWidth+1  current word count, 0..depth
//  oOverflow       out  1             sticky: write attempted while full
//  oUnderflow      out  1             sticky: read attempted while empty
//  iClrFlags       in   1             clears oOverflow/oUnderflow
//
// BEHAVIOUR
//  - Reset (iRst=1 at edge): pointers=0, oLevel=0, oRdEmpty=1, oRdAlmostEmpty=1, oWrFull=0,
//    oWrAlmostFull=0, oRdData=0, oRdValid=0, oOverflow=0, oUnderflow=0. Contents discarded;
//    reset mid-operation drops any pending read/write in that cycle. Reset beats all inputs.
//  - Write accepted iff iWrEn && !oWrFull; mem[wr_ptr]<=iWrData, wr_ptr++ (wraps depth-1 -> 0).
//  - Read accepted iff iRdEn && !oRdEmpty; rd_ptr++ (wraps).
//  - Full/empty are the values registered at cycle start: write while full is rejected even
//    with a simultaneous accepted read; read while empty is rejected even with a simultaneous write.
//  - oLevel: +1 write only, -1 read only, unchanged when both or neither accepted; registered.
//    oWrFull/oRdEmpty/almost flags decoded from registered oLevel (no extra latency).
//  - Standard mode: oRdData registered; word valid the cycle after read accepted, with oRdValid=1
//    for exactly that cycle. oRdData holds last value otherwise. Write-to-readable latency 1 cycle.
//  - oOverflow set on iWrEn && oWrFull; oUnderflow set on iRdEn && oRdEmpty. Held until iClrFlags
//    or reset; if set and clear in same cycle, set wins.
//  - Rejected accesses change no pointer, level or data.
//
// CONFIGURATION
//  FIFO_FWFT_EN defined: first-word-fall-through. oRdData = mem[rd_ptr] (comb. read) whenever
//    !oRdEmpty; oRdValid = !oRdEmpty; iRdEn acknowledges/pops the presented word. First word visible
//    the cycle after its write is accepted. oRdData=0 while empty.
//  FIFO_FWFT_EN undefined: standard registered-read mode above.
//
// TESTING  (pDataWidth=8, pAddrWidth=3, pAlmostFull=6, pAlmostEmpty=1)
//  1 Reset: assert iRst 2 cycles with iWrEn/iRdEn high -> all outputs at reset values, oLevel=0.
//  2 Fill: write 0x01..0x08 -> oLevel 1..8; oRdAlmostEmpty drops at level 2; oWrAlmostFull at 6;
//    oWrFull at 8; 9th write 0x09 rejected, oOverflow=1, oLevel stays 8.
//  3 Drain: read 8 -> oRdData 0x01..0x08 in order, oRdValid 1 cycle after each iRdEn; extra
//    read -> oUnderflow=1, oRdValid=0; iClrFlags pulse -> both flags 0.
//  4 Simultaneous: at level 4 write+read 20 cycles -> oLevel stays 4, data order preserved across
//    pointer wrap; at level 8 write+read -> read ok, write rejected, level 7, oOverflow=1.
//  5 Reset mid-stream: at level 5 assert iRst -> oLevel=0, oRdEmpty=1; next read returns first
//    word written after reset, not stale data.
//  6 FIFO_FWFT_EN: write 0xA5 to empty -> next cycle oRdValid=1, oRdData=0xA5 with no iRdEn;
//    iRdEn pulse -> oRdEmpty=1, oRdData=0.

Source files
------------

// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: write/read handshake and status bundle of the parametrised sync FIFO.
// The producer/consumer side uses the master modport; the FIFO itself uses the slave modport.
interface fifo_sync_param_if #(
   parameter int unsigned pDataWidth = 8,
   parameter int unsigned pAddrWidth = 3
);

   localparam int unsigned cLevelW = pAddrWidth + 1;

   // Write side
   logic                  iWrEn;
   logic [pDataWidth-1:0] iWrData;
   logic                  oWrFull;
   logic                  oWrAlmostFull;

   // Read side
   logic                  iRdEn;
   logic [pDataWidth-1:0] oRdData;
   logic                  oRdValid;
   logic                  oRdEmpty;
   logic                  oRdAlmostEmpty;

   // Status / error reporting
   logic [cLevelW-1:0]    oLevel;
   logic                  oOverflow;
   logic                  oUnderflow;
   logic                  iClrFlags;

   // Producer/consumer view
   modport master (
      output iWrEn, iWrData, iRdEn, iClrFlags,
      input  oWrFull, oWrAlmostFull, oRdData, oRdValid, oRdEmpty, oRdAlmostEmpty,
             oLevel, oOverflow, oUnderflow
   );

   // FIFO view
   modport slave (
      input  iWrEn, iWrData, iRdEn, iClrFlags,
      output oWrFull, oWrAlmostFull, oRdData, oRdValid, oRdEmpty, oRdAlmostEmpty,
             oLevel, oOverflow, oUnderflow
   );

endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: parametrised single-clock FIFO with occupancy count, almost-full/empty
// thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads (head word presented
// combinationally); without it the read port is a registered pop with a one-cycle oRdValid.
module fifo_sync_param #(
   parameter int unsigned pDataWidth   = 8,
   parameter int unsigned pAddrWidth   = 3,
   parameter int unsigned pAlmostFull  = 6,
   parameter int unsigned pAlmostEmpty = 1
) (
   input logic              iClk,
   input logic              iRst,
   fifo_sync_param_if.slave fifoBus
);

   localparam int unsigned cDepth  = 1 << pAddrWidth;
   localparam int unsigned cLevelW = pAddrWidth + 1;

   localparam logic [cLevelW-1:0]    cLevelMax   = cLevelW'(cDepth);
   localparam logic [cLevelW-1:0]    cAlmostFull = cLevelW'(pAlmostFull);
   localparam logic [cLevelW-1:0]    cAlmostEmpty = cLevelW'(pAlmostEmpty);
   localparam logic [pAddrWidth-1:0] cPtrOne     = pAddrWidth'(1);

   logic [pDataWidth-1:0] mem [cDepth];

   logic [pAddrWidth-1:0] wrPtr;
   logic [pAddrWidth-1:0] rdPtr;
   logic [cLevelW-1:0]    level;
   logic [cLevelW-1:0]    levelNext;

   logic full;
   logic almostFull;
   logic empty;
   logic almostEmpty;
   logic overflow;
   logic underflow;

   logic wrAccept;
   logic rdAccept;

   // Accept decisions use the status registered at cycle start, so a full FIFO never
   // takes a write and an empty one never gives a read, whatever the other side does.
   assign wrAccept = fifoBus.iWrEn && !full;
   assign rdAccept = fifoBus.iRdEn && !empty;

   // Next occupancy; simultaneous accepted write and read leave it unchanged.
   always_comb begin
      levelNext = level;
      if (wrAccept && !rdAccept) begin
         levelNext = level + cLevelW'(1);
      end else if (rdAccept && !wrAccept) begin
         levelNext = level - cLevelW'(1);
      end
   end

   // Pointers, level and status flags; flags are decoded from the next level so they
   // line up with the registered level in the same cycle.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         wrPtr       <= '0;
         rdPtr       <= '0;
         level       <= '0;
         full        <= 1'b0;
         almostFull  <= 1'b0;
         empty       <= 1'b1;
         almostEmpty <= 1'b1;
      end else begin
         if (wrAccept) begin
            wrPtr <= wrPtr + cPtrOne;
         end
         if (rdAccept) begin
            rdPtr <= rdPtr + cPtrOne;
         end
         level       <= levelNext;
         full        <= (levelNext == cLevelMax);
         almostFull  <= (levelNext >= cAlmostFull);
         empty       <= (levelNext == '0);
         almostEmpty <= (levelNext <= cAlmostEmpty);
      end
   end

   // Sticky error flags; a new error in the clearing cycle keeps the flag set.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (fifoBus.iWrEn && full)  || (overflow  && !fifoBus.iClrFlags);
         underflow <= (fifoBus.iRdEn && empty) || (underflow && !fifoBus.iClrFlags);
      end
   end

   // Storage array; contents are not reset, reset only discards them via the pointers.
   always_ff @(posedge iClk) begin
      if (wrAccept && !iRst) begin
         mem[wrPtr] <= fifoBus.iWrData;
      end
   end

`ifdef FIFO_FWFT_EN
   // Head word presented directly while not empty; iRdEn acknowledges it.
   assign fifoBus.oRdData  = empty ? '0 : mem[rdPtr];
   assign fifoBus.oRdValid = !empty;
`else
   logic [pDataWidth-1:0] rdData;
   logic                  rdValid;

   // Registered read: data lands the cycle after the pop and is held until the next pop.
   always_ff @(posedge iClk) begin
      if (iRst) begin
         rdData  <= '0;
         rdValid <= 1'b0;
      end else begin
         rdValid <= rdAccept;
         if (rdAccept) begin
            rdData <= mem[rdPtr];
         end
      end
   end

   assign fifoBus.oRdData  = rdData;
   assign fifoBus.oRdValid = rdValid;
`endif

   assign fifoBus.oWrFull        = full;
   assign fifoBus.oWrAlmostFull  = almostFull;
   assign fifoBus.oRdEmpty       = empty;
   assign fifoBus.oRdAlmostEmpty = almostEmpty;
   assign fifoBus.oLevel         = level;
   assign fifoBus.oOverflow      = overflow;
   assign fifoBus.oUnderflow     = underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed self-checking bench for fifo_sync_param (8-bit x 8 deep,
// almost-full 6, almost-empty 1). Covers both read modes, selected by FIFO_FWFT_EN.
module tb_fifo_sync_param;

   logic iClk;
   logic iRst;

   int nCompared;
   int nMismatched;

   fifo_sync_param_if #(.pDataWidth(8), .pAddrWidth(3)) fifoBus ();

   fifo_sync_param #(
      .pDataWidth  (8),
      .pAddrWidth  (3),
      .pAlmostFull (6),
      .pAlmostEmpty(1)
   ) dut (
      .iClk   (iClk),
      .iRst   (iRst),
      .fifoBus(fifoBus)
   );

   // Expected status while filling, indexed by level 1..8
   logic [7:0] expAlmostEmpty;
   logic [7:0] expAlmostFull;
   logic [7:0] expFull;

   initial iClk = 1'b0;
   always #5 iClk = ~iClk;

   // Compare one observed value against its expected value
   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge iClk);
      #1;
   endtask

   // Pop one word and check it against exp, in whichever read mode is built
   task automatic readCheck(input logic [7:0] exp, input string tag);
`ifdef FIFO_FWFT_EN
      checkVal({tag, " valid"}, 32'(fifoBus.oRdValid), 32'd1);
      checkVal({tag, " data"},  32'(fifoBus.oRdData),  32'(exp));
      fifoBus.iRdEn = 1'b1;
      step();
      fifoBus.iRdEn = 1'b0;
`else
      fifoBus.iRdEn = 1'b1;
      step();
      fifoBus.iRdEn = 1'b0;
      checkVal({tag, " valid"}, 32'(fifoBus.oRdValid), 32'd1);
      checkVal({tag, " data"},  32'(fifoBus.oRdData),  32'(exp));
`endif
   endtask

   // Write one word
   task automatic writeWord(input logic [7:0] data);
      fifoBus.iWrEn   = 1'b1;
      fifoBus.iWrData = data;
      step();
      fifoBus.iWrEn   = 1'b0;
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      // bit i-1 holds the expected flag at level i
      expAlmostEmpty = 8'b0000_0001;
      expAlmostFull  = 8'b1110_0000;
      expFull        = 8'b1000_0000;

      fifoBus.iWrEn     = 1'b1;
      fifoBus.iWrData   = 8'hEE;
      fifoBus.iRdEn     = 1'b1;
      fifoBus.iClrFlags = 1'b0;
      iRst              = 1'b1;

      // 1: reset beats simultaneous write/read requests
      step();
      step();
      checkVal("rst level",       32'(fifoBus.oLevel),         32'd0);
      checkVal("rst empty",       32'(fifoBus.oRdEmpty),       32'd1);
      checkVal("rst almostEmpty", 32'(fifoBus.oRdAlmostEmpty), 32'd1);
      checkVal("rst full",        32'(fifoBus.oWrFull),        32'd0);
      checkVal("rst almostFull",  32'(fifoBus.oWrAlmostFull),  32'd0);
      checkVal("rst rdData",      32'(fifoBus.oRdData),        32'd0);
      checkVal("rst rdValid",     32'(fifoBus.oRdValid),       32'd0);
      checkVal("rst overflow",    32'(fifoBus.oOverflow),      32'd0);
      checkVal("rst underflow",   32'(fifoBus.oUnderflow),     32'd0);
      iRst          = 1'b0;
      fifoBus.iWrEn = 1'b0;
      fifoBus.iRdEn = 1'b0;

      // 2: fill 0x01..0x08, then a rejected ninth write
      for (int i = 1; i <= 8; i++) begin
         writeWord(8'(i));
         checkVal($sformatf("fill%0d level", i),       32'(fifoBus.oLevel),         32'(i));
         checkVal($sformatf("fill%0d almostEmpty", i), 32'(fifoBus.oRdAlmostEmpty), 32'(expAlmostEmpty[i-1]));
         checkVal($sformatf("fill%0d almostFull", i),  32'(fifoBus.oWrAlmostFull),  32'(expAlmostFull[i-1]));
         checkVal($sformatf("fill%0d full", i),        32'(fifoBus.oWrFull),        32'(expFull[i-1]));
         checkVal($sformatf("fill%0d empty", i),       32'(fifoBus.oRdEmpty),       32'd0);
      end
      writeWord(8'h09);
      checkVal("ovf level",    32'(fifoBus.oLevel),    32'd8);
      checkVal("ovf overflow", 32'(fifoBus.oOverflow), 32'd1);

      // 3: drain in order, then underflow and flag clear
      for (int i = 1; i <= 8; i++) begin
         readCheck(8'(i), $sformatf("drain%0d", i));
         checkVal($sformatf("drain%0d level", i), 32'(fifoBus.oLevel), 32'(8 - i));
      end
      checkVal("drain empty", 32'(fifoBus.oRdEmpty), 32'd1);
      fifoBus.iRdEn = 1'b1;
      step();
      fifoBus.iRdEn = 1'b0;
      checkVal("unf underflow",  32'(fifoBus.oUnderflow), 32'd1);
      checkVal("unf rdValid",    32'(fifoBus.oRdValid),   32'd0);
      checkVal("unf level",      32'(fifoBus.oLevel),     32'd0);
      checkVal("ovf sticky",     32'(fifoBus.oOverflow),  32'd1);
`ifdef FIFO_FWFT_EN
      checkVal("unf rdData",     32'(fifoBus.oRdData),    32'd0);
`else
      checkVal("unf rdData hold", 32'(fifoBus.oRdData),   32'h08);
`endif
      fifoBus.iClrFlags = 1'b1;
      step();
      fifoBus.iClrFlags = 1'b0;
      checkVal("clr overflow",  32'(fifoBus.oOverflow),  32'd0);
      checkVal("clr underflow", 32'(fifoBus.oUnderflow), 32'd0);

      // Underflow set in the same cycle as clear: set wins
      fifoBus.iRdEn     = 1'b1;
      fifoBus.iClrFlags = 1'b1;
      step();
      fifoBus.iRdEn     = 1'b0;
      fifoBus.iClrFlags = 1'b0;
      checkVal("setclr underflow", 32'(fifoBus.oUnderflow), 32'd1);
      fifoBus.iClrFlags = 1'b1;
      step();
      fifoBus.iClrFlags = 1'b0;
      checkVal("setclr cleared", 32'(fifoBus.oUnderflow), 32'd0);

      // 4: level 4, then 20 cycles of simultaneous write+read across pointer wrap
      for (int i = 0; i < 4; i++) writeWord(8'(8'h10 + i));
      checkVal("sim start level", 32'(fifoBus.oLevel), 32'd4);
      for (int k = 0; k < 20; k++) begin
         fifoBus.iWrEn   = 1'b1;
         fifoBus.iWrData = 8'(8'h14 + k);
`ifdef FIFO_FWFT_EN
         checkVal($sformatf("sim%0d data", k), 32'(fifoBus.oRdData), 32'(8'h10 + k));
         fifoBus.iRdEn = 1'b1;
         step();
`else
         fifoBus.iRdEn = 1'b1;
         step();
         checkVal($sformatf("sim%0d valid", k), 32'(fifoBus.oRdValid), 32'd1);
         checkVal($sformatf("sim%0d data", k),  32'(fifoBus.oRdData),  32'(8'h10 + k));
`endif
         checkVal($sformatf("sim%0d level", k), 32'(fifoBus.oLevel), 32'd4);
      end
      fifoBus.iWrEn = 1'b0;
      fifoBus.iRdEn = 1'b0;
      // Remaining words 0x24..0x27; add 0x28..0x2B to reach full
      for (int i = 0; i < 4; i++) writeWord(8'(8'h28 + i));
      checkVal("simfull level", 32'(fifoBus.oLevel),  32'd8);
      checkVal("simfull full",  32'(fifoBus.oWrFull), 32'd1);
      fifoBus.iWrEn   = 1'b1;
      fifoBus.iWrData = 8'h99;
`ifdef FIFO_FWFT_EN
      checkVal("simfull data", 32'(fifoBus.oRdData), 32'h24);
      fifoBus.iRdEn = 1'b1;
      step();
`else
      fifoBus.iRdEn = 1'b1;
      step();
      checkVal("simfull data", 32'(fifoBus.oRdData), 32'h24);
`endif
      fifoBus.iWrEn = 1'b0;
      fifoBus.iRdEn = 1'b0;
      checkVal("simfull level7",   32'(fifoBus.oLevel),    32'd7);
      checkVal("simfull overflow", 32'(fifoBus.oOverflow), 32'd1);
      checkVal("simfull notfull",  32'(fifoBus.oWrFull),   32'd0);
      fifoBus.iClrFlags = 1'b1;
      step();
      fifoBus.iClrFlags = 1'b0;

      // 5: reset at level 5 discards contents
      readCheck(8'h25, "pre-rst a");
      readCheck(8'h26, "pre-rst b");
      checkVal("pre-rst level", 32'(fifoBus.oLevel), 32'd5);
      iRst = 1'b1;
      step();
      iRst = 1'b0;
      checkVal("midrst level",   32'(fifoBus.oLevel),   32'd0);
      checkVal("midrst empty",   32'(fifoBus.oRdEmpty), 32'd1);
      checkVal("midrst rdValid", 32'(fifoBus.oRdValid), 32'd0);
      writeWord(8'h5A);
      readCheck(8'h5A, "post-rst");
      checkVal("post-rst empty", 32'(fifoBus.oRdEmpty), 32'd1);

`ifdef FIFO_FWFT_EN
      // 6: fall-through presentation without iRdEn, then ack
      writeWord(8'hA5);
      checkVal("fwft valid", 32'(fifoBus.oRdValid), 32'd1);
      checkVal("fwft data",  32'(fifoBus.oRdData),  32'hA5);
      step();
      checkVal("fwft hold",  32'(fifoBus.oRdData),  32'hA5);
      fifoBus.iRdEn = 1'b1;
      step();
      fifoBus.iRdEn = 1'b0;
      checkVal("fwft empty",   32'(fifoBus.oRdEmpty), 32'd1);
      checkVal("fwft data0",   32'(fifoBus.oRdData),  32'd0);
      checkVal("fwft invalid", 32'(fifoBus.oRdValid), 32'd0);
`else
      // oRdValid is a single-cycle pulse after a pop
      step();
      checkVal("rdValid pulse", 32'(fifoBus.oRdValid), 32'd0);
      checkVal("rdData hold",   32'(fifoBus.oRdData),  32'h5A);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
